demosaic_mul_arbiter: RTL and testbench

- Shares one pipelined unsigned 20x8 multiplier among NUM_REQ requesters inside the demosaic IP. The 27-bit product is truncated.
- Requesters are the per-colour interpolation lanes. They present operands with a valid/ready handshake.
- A round-robin arbiter grants at most one request per cycle.
- A tag travels with each operand pair so the product returns to the requester that issued it after a fixed latency.

---
 rtl/demosaic_mul_pkg.sv | 24 ++
 rtl/demosaic_rr_arbiter.sv | 56 +++++
 rtl/demosaic_mul_arbiter.sv | 125 ++++++++++++
 tb/tb_demosaic_mul_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/demosaic_mul_pkg.sv
// rtl/demosaic_mul_pkg.sv - shared widths and pipeline slot type for the demosaic multiplier arbiter
// Contents: operand/product widths, tag width helper, pipeline slot struct.
package demosaic_mul_pkg;

  localparam int A_W     = 20;
  localparam int B_W     = 8;
  localparam int P_W     = 27;
  localparam int MAX_REQ = 8;

  // Index width for n requesters; never narrower than one bit.
  function automatic int tag_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Slot tags are sized for the largest supported requester count.
  localparam int TAG_W = tag_width(MAX_REQ);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [P_W-1:0]   prod;
  } slot_t;

endpackage

// File: rtl/demosaic_rr_arbiter.sv
// rtl/demosaic_rr_arbiter.sv - round-robin one-hot grant with last-winner pointer
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-requester request
//   en         : grant enable (0 forces grant to zero)
//   accept     : handshake completed this cycle; pointer moves to the winner
//   grant      : one-hot or zero grant, combinational
module demosaic_rr_arbiter
  import demosaic_mul_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PW = tag_width(NUM_REQ);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win_idx;
  logic          found;
  int            idx;

  // Search starts just after the last winner and wraps around.
  always_comb begin
    grant   = '0;
    win_idx = ptr_q;
    found   = 1'b0;
    idx     = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        win_idx    = PW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = win_idx;
  end

  // Pointer starts at the last requester so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= PW'(NUM_REQ - 1);
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/demosaic_mul_arbiter.sv
// rtl/demosaic_mul_arbiter.sv - shared pipelined 20x8 multiplier with round-robin requesters
// Ports:
//   ap_clk, ap_rst_n : clock, asynchronous active-low reset
//   en               : grant enable; pipeline drains while low
//   req_valid/ready  : per-requester operand handshake (ready is one-hot, combinational)
//   req_a, req_b     : packed operands, requester i at [i*W +: W]
//   rsp_valid        : one-cycle result strobe per requester
//   rsp_p            : truncated product during the strobe
//   inflight, busy   : products in the pipeline, and inflight != 0
module demosaic_mul_arbiter
  import demosaic_mul_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int MUL_STAGES = 3
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst_n,
  input  logic                            en,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*A_W-1:0]          req_a,
  input  logic [NUM_REQ*B_W-1:0]          req_b,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [P_W-1:0]                  rsp_p,
  output logic [$clog2(MUL_STAGES+1)-1:0] inflight,
  output logic                            busy
);

  localparam int CNT_W  = $clog2(MUL_STAGES + 1);
  // Intermediate slots between acceptance and the output registers.
  localparam int PIPE_N = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;

  logic             accept;
  logic             retire;
  logic [A_W-1:0]   sel_a;
  logic [B_W-1:0]   sel_b;
  logic [TAG_W-1:0] sel_tag;
  slot_t            stage_in;
  slot_t            last_in;
  slot_t            slot_q [PIPE_N];
  slot_t            slot_d [PIPE_N];

  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [P_W-1:0]     rsp_p_q, rsp_p_d;
  logic [CNT_W-1:0]   inflight_q, inflight_d;
  logic               busy_q, busy_d;

  demosaic_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk    (ap_clk),
    .rst_n  (ap_rst_n),
    .req    (req_valid),
    .en     (en),
    .accept (accept),
    .grant  (req_ready)
  );

  assign accept = |(req_valid & req_ready);
  assign retire = |rsp_valid_q;

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_tag = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_a   = req_a[i*A_W +: A_W];
        sel_b   = req_b[i*B_W +: B_W];
        sel_tag = TAG_W'(i);
      end
    end
  end

  // The product is formed ahead of the first register; the total
  // register count from acceptance to rsp_* is still MUL_STAGES.
  always_comb begin
    stage_in.valid = accept;
    stage_in.tag   = sel_tag;
    stage_in.prod  = P_W'(sel_a) * P_W'(sel_b);
  end

  always_comb begin
    for (int k = 0; k < PIPE_N; k++) slot_d[k] = slot_q[k];
    slot_d[0] = stage_in;
    for (int k = 1; k < PIPE_N; k++) slot_d[k] = slot_q[k-1];
    last_in = (MUL_STAGES > 1) ? slot_q[PIPE_N-1] : stage_in;
  end

  always_comb begin
    rsp_valid_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid_d[i] = last_in.valid && (last_in.tag == TAG_W'(i));
    end
    rsp_p_d = last_in.prod;
  end

  // A product counts as in flight until its strobe cycle ends.
  always_comb begin
    inflight_d = inflight_q;
    if (accept && !retire)      inflight_d = inflight_q + CNT_W'(1);
    else if (!accept && retire) inflight_d = inflight_q - CNT_W'(1);
    busy_d = (inflight_d != '0);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int k = 0; k < PIPE_N; k++) slot_q[k] <= '0;
      rsp_valid_q <= '0;
      rsp_p_q     <= '0;
      inflight_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      for (int k = 0; k < PIPE_N; k++) slot_q[k] <= slot_d[k];
      rsp_valid_q <= rsp_valid_d;
      rsp_p_q     <= rsp_p_d;
      inflight_q  <= inflight_d;
      busy_q      <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_p     = rsp_p_q;
  assign inflight  = inflight_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_demosaic_mul_arbiter.sv
// tb/tb_demosaic_mul_arbiter.sv - scoreboard bench for demosaic_mul_arbiter
module tb_demosaic_mul_arbiter;

  localparam int N   = 4;
  localparam int S   = 3;
  localparam int AW  = 20;
  localparam int BW  = 8;
  localparam int PW  = 27;
  localparam int CW  = $clog2(S + 1);

  logic            ap_clk = 1'b0;
  logic            ap_rst_n;
  logic            en;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_a;
  logic [N*BW-1:0] req_b;
  logic [N-1:0]    rsp_valid;
  logic [PW-1:0]   rsp_p;
  logic [CW-1:0]   inflight;
  logic            busy;

  demosaic_mul_arbiter #(.NUM_REQ(N), .MUL_STAGES(S)) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .en        (en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_p     (rsp_p),
    .inflight  (inflight),
    .busy      (busy)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    int     tag;
    longint p;
    int     due;
  } exp_t;

  exp_t   sb[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     ncount   = 0;
  bit     in_reset = 1'b1;
  int     ptr_m;
  int     exp_inf;
  exp_t   e;

  logic [N-1:0]  v;
  logic [AW-1:0] a_r [N];
  logic [BW-1:0] b_r [N];
  logic          en_r;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint model_prod(input logic [AW-1:0] a, input logic [BW-1:0] b);
    return (longint'(a) * longint'(b)) % (longint'(1) << PW);
  endfunction

  function automatic int model_grant();
    int idx;
    if (!en_r) return -1;
    for (int off = 1; off <= N; off++) begin
      idx = (ptr_m + off) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic new_ops(input int i);
    a_r[i] = ($urandom_range(0, 7) == 0) ? 20'hFFFFF : AW'($urandom);
    b_r[i] = ($urandom_range(0, 7) == 0) ? 8'hFF : BW'($urandom);
  endtask

  task automatic drive();
    en        = en_r;
    req_valid = v;
    for (int i = 0; i < N; i++) begin
      req_a[i*AW +: AW] = a_r[i];
      req_b[i*BW +: BW] = b_r[i];
    end
  endtask

  // One cycle: apply held stimulus, predict the grant, record the expected product.
  task automatic step(input bit refill);
    int g;
    logic [N-1:0] exp_rdy;
    @(posedge ap_clk);
    #1;
    drive();
    #3;
    g = model_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (g >= 0) begin
      sb.push_back('{g, model_prod(a_r[g], b_r[g]), ncount + 1 + S});
      ptr_m = g;
      if (refill) new_ops(g);
      else v[g] = 1'b0;
    end
  endtask

  task automatic drain_reqs();
    en_r = 1'b1;
    for (int k = 0; k < 2 * N && v != '0; k++) step(1'b0);
    chk("reqs_drained", 64'(v), 64'd0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0);
  endtask

  // Monitor: inflight/busy against the scoreboard, strobes popped in order.
  always @(negedge ap_clk) begin
    ncount++;
    if (!in_reset) begin
      exp_inf = 0;
      foreach (sb[i]) if (sb[i].due - S < ncount) exp_inf++;
      chk("inflight", 64'(inflight), 64'(exp_inf));
      chk("busy", 64'(busy), 64'(exp_inf != 0));
      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          chk("spurious_rsp_valid", 64'(rsp_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_latency", 64'(ncount), 64'(e.due));
          chk("rsp_tag", 64'(rsp_valid), 64'd1 << e.tag);
          chk("rsp_p", 64'(rsp_p), 64'(e.p));
        end
      end else if (sb.size() > 0 && sb[0].due <= ncount) begin
        e = sb.pop_front();
        chk("missing_rsp", 64'(rsp_valid), 64'd1 << e.tag);
      end
    end
  end

  initial begin
    ap_rst_n  = 1'b0;
    en_r      = 1'b0;
    v         = '0;
    for (int i = 0; i < N; i++) begin a_r[i] = '0; b_r[i] = '0; end
    ptr_m     = N - 1;
    drive();
    #2;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_p", 64'(rsp_p), 64'd0);
    chk("reset_inflight", 64'(inflight), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_ready", 64'(req_ready), 64'd0);
    repeat (2) @(posedge ap_clk);
    #3;
    ap_rst_n = 1'b1;
    in_reset = 1'b0;

    // Single request, then a full-scale operand pair for truncation.
    en_r = 1'b1;
    v[0] = 1'b1; a_r[0] = 20'd1000; b_r[0] = 8'd200;
    step(1'b0);
    idle(S + 2);
    v[1] = 1'b1; a_r[1] = 20'hFFFFF; b_r[1] = 8'hFF;
    step(1'b0);
    idle(S + 2);

    // Reset with three products in flight.
    v = '1;
    for (int i = 0; i < N; i++) new_ops(i);
    repeat (3) step(1'b1);
    @(posedge ap_clk);
    #2;
    chk("pre_reset_inflight", 64'(inflight), 64'(sb.size()));
    ap_rst_n = 1'b0;
    in_reset = 1'b1;
    sb.delete();
    #1;
    chk("async_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("async_inflight", 64'(inflight), 64'd0);
    chk("async_busy", 64'(busy), 64'd0);
    v = '0;
    ptr_m = N - 1;
    drive();
    repeat (2) @(posedge ap_clk);
    #3;
    ap_rst_n = 1'b1;
    in_reset = 1'b0;

    // Full contention: expect 0,1,2,3,0,1,2,3 with back-to-back strobes.
    v = '1;
    for (int i = 0; i < N; i++) new_ops(i);
    repeat (8) step(1'b1);
    drain_reqs();
    idle(S + 2);

    // Fill the pipeline, then block grants while it drains.
    v = '1;
    for (int i = 0; i < N; i++) new_ops(i);
    repeat (4) step(1'b1);
    en_r = 1'b0;
    repeat (S + 3) step(1'b1);
    drain_reqs();
    idle(S + 2);

    // Random soak.
    for (int k = 0; k < 600; k++) begin
      en_r = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < N; i++) begin
        if (!v[i] && $urandom_range(0, 2) == 0) begin
          v[i] = 1'b1;
          new_ops(i);
        end
      end
      step(1'($urandom_range(0, 1)));
    end
    drain_reqs();
    idle(S + 3);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
